// File: rtl/prbs_frame_scheduler_pkg.sv
// Shared types and constants for the PRBS7 frame scheduler: FSM state enum,
// generator seed, default preamble and the frame-expansion helper.
package prbs_pkg;

    localparam int unsigned PRBS_FRAME_W  = 32;
    localparam logic [6:0]  PRBS7_SEED    = 7'h7F;
    localparam logic [31:0] DEF_SYNC_WORD = 32'hA5A5_F00F;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SYNC,
        PAYLOAD,
        DONE
    } sched_state_e;

    // Unrolls 32 steps of x^7+x^6+1; the first generated bit lands in the MSB.
    function automatic logic [PRBS_FRAME_W-1:0] prbs7_expand(input logic [6:0] seed_state);
        logic [6:0]              s;
        logic [PRBS_FRAME_W-1:0] f;
        logic                    nb;
        s = seed_state;
        f = '0;
        for (int unsigned i = 0; i < PRBS_FRAME_W; i++) begin
            nb                     = s[6] ^ s[5];
            f[PRBS_FRAME_W-1-i]    = nb;
            s                      = {s[5:0], nb};
        end
        return f;
    endfunction

endpackage

// File: rtl/prbs_frame_scheduler_if.sv
// Transmit-link handshake bundle between the scheduler (master) and the
// serializer (slave).
interface prbs_frame_scheduler_if
    import prbs_pkg::*;
#(
    parameter int unsigned FRAME_W = PRBS_FRAME_W
);
    logic [FRAME_W-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               tx_sof;

    modport master (output tx_data, output tx_valid, output tx_sof, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_sof, output tx_ready);
endinterface

// File: rtl/prbs_frame_scheduler_frame_gen.sv
// PRBS7 frame generator: holds the 7-bit state, presents the current 32-bit
// frame and the state that follows it.
module prbs7_frame_gen
    import prbs_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    seed,
    input  logic                    advance,
    output logic [PRBS_FRAME_W-1:0] frame,
    output logic [6:0]              state_next
);

    logic [6:0] state;

    // After a frame the register holds the last seven bits emitted.
    always_comb begin
        frame      = prbs7_expand(state);
        state_next = frame[6:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n || seed) begin
            state <= PRBS7_SEED;
        end else if (advance) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/prbs_frame_scheduler.sv
// Sequences reseed, sync preamble and PRBS7 payload frames onto the tx link.
// Optional PRBS_SCHED_ERR_INJECT_EN adds err_inj, a one-shot payload bit-0 flip.
module prbs_frame_scheduler
    import prbs_pkg::*;
#(
    parameter int unsigned        FRAME_W   = PRBS_FRAME_W,
    parameter int unsigned        CNT_W     = 16,
    parameter logic [FRAME_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int unsigned        SYNC_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_W-1:0]      frame_count,
`ifdef PRBS_SCHED_ERR_INJECT_EN
    input  logic                  err_inj,
`endif
    prbs_frame_scheduler_if.master tx,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      frames_sent
);

    sched_state_e       state;
    logic [CNT_W-1:0]   cnt_lat;
    logic [3:0]         sync_cnt;

    logic [FRAME_W-1:0] gen_frame;
    logic [6:0]         gen_state_next;
    logic [FRAME_W-1:0] payload_next;
    logic [FRAME_W-1:0] inj_mask;
    logic [CNT_W-1:0]   frames_inc;
    logic               accept;
    logic               last_sync;
    logic               last_frame;
    logic               load_payload;
    logic               gen_seed;
    logic               gen_advance;
    logic               inj_bit;

    always_comb begin
        accept       = tx.tx_valid & tx.tx_ready;
        frames_inc   = frames_sent + CNT_W'(1);
        last_sync    = (sync_cnt == 4'(SYNC_LEN - 1));
        last_frame   = (cnt_lat != '0) && (frames_inc == cnt_lat);
        load_payload = accept && (((state == SYNC) && last_sync) ||
                                  ((state == PAYLOAD) && !last_frame));
        gen_seed     = (state == SEED);
        gen_advance  = (state == PAYLOAD) && accept;
        // Registered tx_data must show the frame after the advance, so expand ahead.
        payload_next = prbs7_expand(gen_state_next);
        inj_mask     = {{(FRAME_W-1){1'b0}}, inj_bit};
    end

    prbs7_frame_gen u_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .seed       (gen_seed),
        .advance    (gen_advance),
        .frame      (gen_frame),
        .state_next (gen_state_next)
    );

`ifdef PRBS_SCHED_ERR_INJECT_EN
    logic armed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (abort && state != IDLE) begin
            armed <= 1'b0;
        end else if (load_payload && armed) begin
            armed <= 1'b0;
        end else if (err_inj) begin
            armed <= 1'b1;
        end
    end

    assign inj_bit = armed;
`else
    assign inj_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_sof   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            cnt_lat     <= '0;
            sync_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // An accept coinciding with abort still counts as delivered.
                state       <= IDLE;
                tx.tx_valid <= 1'b0;
                tx.tx_sof   <= 1'b0;
                busy        <= 1'b0;
                if (state == PAYLOAD && accept) begin
                    frames_sent <= frames_inc;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            cnt_lat <= frame_count;
                            busy    <= 1'b1;
                            state   <= SEED;
                        end
                    end
                    SEED: begin
                        frames_sent <= '0;
                        sync_cnt    <= '0;
                        tx.tx_valid <= 1'b1;
                        tx.tx_data  <= SYNC_WORD;
                        tx.tx_sof   <= 1'b1;
                        state       <= SYNC;
                    end
                    SYNC: begin
                        if (accept) begin
                            tx.tx_sof <= 1'b0;
                            sync_cnt  <= sync_cnt + 4'd1;
                            if (last_sync) begin
                                tx.tx_data <= gen_frame ^ inj_mask;
                                state      <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (accept) begin
                            frames_sent <= frames_inc;
                            if (last_frame) begin
                                tx.tx_valid <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else begin
                                tx.tx_data <= payload_next ^ inj_mask;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_frame_scheduler.sv
// Scoreboard bench for prbs_frame_scheduler: expected beats are queued from a
// bit-serial PRBS7 model and popped as the link accepts them.
module tb_prbs_frame_scheduler;

    localparam logic [31:0] SYNC_W = 32'hA5A5_F00F;
    localparam int          SYNC_N = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] frame_count;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;
`ifdef PRBS_SCHED_ERR_INJECT_EN
    logic        err_inj;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0]  mstate;
    logic [32:0] exp_q[$];

    prbs_frame_scheduler_if #(.FRAME_W(32)) tx_if ();

    prbs_frame_scheduler #(
        .FRAME_W   (32),
        .CNT_W     (16),
        .SYNC_WORD (32'hA5A5_F00F),
        .SYNC_LEN  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .frame_count (frame_count),
`ifdef PRBS_SCHED_ERR_INJECT_EN
        .err_inj     (err_inj),
`endif
        .tx          (tx_if),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_frame();
        logic [31:0] f;
        logic        b;
        f = '0;
        for (int i = 0; i < 32; i++) begin
            b      = mstate[6] ^ mstate[5];
            f      = {f[30:0], b};
            mstate = {mstate[5:0], b};
        end
        return f;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame_count = '0;
        tx_if.tx_ready = 1'b0;
`ifdef PRBS_SCHED_ERR_INJECT_EN
        err_inj = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (tx_if.tx_data !== 32'h0) begin miscompares++; $display("FAIL reset_tx_data: got %h want 0", tx_if.tx_data); end
        vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b want 0", tx_if.tx_valid); end
        vectors++; if (tx_if.tx_sof !== 1'b0) begin miscompares++; $display("FAIL reset_tx_sof: got %b want 0", tx_if.tx_sof); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (frames_sent !== 16'h0) begin miscompares++; $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Runs one start..done sequence; cycle 0 is the cycle start is driven.
    task automatic run_sched(input int n, input bit toggle, input int restart_at,
                             input int reset_at, input int inj_at, input int exp_done,
                             output logic [31:0] first_pl);
        logic [32:0] exp_w;
        logic [32:0] obs_w;
        logic [32:0] hold_w;
        bit          held;
        bit          stop;
        int          popped;
        int          done_cyc;
        exp_q.delete();
        mstate = 7'h7F;
        for (int i = 0; i < SYNC_N; i++) exp_q.push_back({(i == 0), SYNC_W});
        for (int j = 0; j < n; j++) begin
            exp_w = {1'b0, model_frame()};
            if (j == 0 && inj_at >= 0) exp_w[0] = ~exp_w[0];
            exp_q.push_back(exp_w);
        end
        first_pl = '0;
        held = 1'b0;
        stop = 1'b0;
        popped = 0;
        done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        frame_count = 16'(n);
        tx_if.tx_ready = 1'b1;
        for (int cyc = 1; cyc <= 200 && !stop; cyc++) begin
            @(posedge clk); #1;
            start   = (cyc == restart_at);
            reset_n = (cyc != reset_at);
`ifdef PRBS_SCHED_ERR_INJECT_EN
            err_inj = (cyc == inj_at);
`endif
            tx_if.tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            obs_w = {tx_if.tx_sof, tx_if.tx_data};
            if (reset_at >= 0 && cyc == reset_at + 1) begin
                vectors++; if (obs_w !== 33'h0) begin miscompares++; $display("FAIL midreset_data_sof: got %h want 0", obs_w); end
                vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", tx_if.tx_valid); end
                vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_busy_done: got %b%b want 00", busy, done); end
                vectors++; if (frames_sent !== 16'h0) begin miscompares++; $display("FAIL midreset_frames_sent: got %0d want 0", frames_sent); end
                stop = 1'b1;
            end else begin
                if (held) begin
                    vectors++;
                    if (obs_w !== hold_w || tx_if.tx_valid !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stall_hold cyc %0d: got v=%b %h want v=1 %h", cyc, tx_if.tx_valid, obs_w, hold_w);
                    end
                end
                held = 1'b0;
                if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_beat cyc %0d: got %h want none", cyc, obs_w);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (obs_w !== exp_w) begin
                            miscompares++;
                            $display("FAIL beat%0d cyc %0d: got %h want %h", popped, cyc, obs_w, exp_w);
                        end
                        if (popped == SYNC_N) first_pl = tx_if.tx_data;
                        popped++;
                    end
                end else if (tx_if.tx_valid === 1'b1) begin
                    held = 1'b1;
                    hold_w = obs_w;
                end
                if (done === 1'b1) begin
                    done_cyc = cyc;
                    stop = 1'b1;
                end
            end
        end
        start = 1'b0;
        reset_n = 1'b1;
`ifdef PRBS_SCHED_ERR_INJECT_EN
        err_inj = 1'b0;
`endif
        if (reset_at < 0) begin
            vectors++;
            if (done_cyc < 0 || (exp_done > 0 && done_cyc != exp_done)) begin
                miscompares++;
                $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done);
            end
            vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL beats_missing: got %0d left want 0", exp_q.size()); end
            vectors++; if (frames_sent !== 16'(n)) begin miscompares++; $display("FAIL frames_sent: got %0d want %0d", frames_sent, n); end
            vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL valid_at_done: got %b want 0", tx_if.tx_valid); end
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL post_done_idle +%0d: got busy=%b done=%b valid=%b want 0 0 0", k + 1, busy, done, tx_if.tx_valid);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] fp;
        run_sched(3, 1'b0, -1, -1, -1, 7, fp);
        vectors++; if (fp !== 32'h020C_28F2) begin miscompares++; $display("FAIL first_payload: got %h want 020c28f2", fp); end
    endtask

    task automatic test_stall();
        logic [31:0] fp;
        run_sched(3, 1'b1, -1, -1, -1, 11, fp);
    endtask

    task automatic test_start_ignored();
        logic [31:0] fp;
        run_sched(4, 1'b0, 5, -1, -1, 8, fp);
    endtask

    task automatic test_start_abort_idle();
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        frame_count = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL start_abort_idle +%0d: got busy=%b valid=%b want 0 0", k, busy, tx_if.tx_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] fp;
        run_sched(5, 1'b0, -1, 6, -1, 0, fp);
        run_sched(3, 1'b0, -1, -1, -1, 7, fp);
        vectors++; if (fp !== 32'h020C_28F2) begin miscompares++; $display("FAIL first_payload_after_reset: got %h want 020c28f2", fp); end
    endtask

`ifdef PRBS_SCHED_ERR_INJECT_EN
    task automatic test_err_inj();
        logic [31:0] fp;
        run_sched(2, 1'b0, -1, -1, 2, 6, fp);
        vectors++; if (fp !== 32'h020C_28F3) begin miscompares++; $display("FAIL err_inj_first: got %h want 020c28f3", fp); end
    endtask
`endif

    task automatic test_stream();
        logic [32:0] exp_w;
        logic [32:0] obs_w;
        int  acc;
        int  popped;
        bit  done_seen;
        bit  abort_cyc;
        bit  check_next;
        bit  finished;
        exp_q.delete();
        mstate = 7'h7F;
        for (int i = 0; i < SYNC_N; i++) exp_q.push_back({(i == 0), SYNC_W});
        acc = 0; popped = 0; done_seen = 0; check_next = 0; finished = 0;
        @(posedge clk); #1;
        start = 1'b1;
        frame_count = 16'd0;
        tx_if.tx_ready = 1'b1;
        for (int cyc = 1; cyc <= 71000 && !finished; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort_cyc = (acc == 69999);
            abort = abort_cyc;
            if (exp_q.size() < 2) exp_q.push_back({1'b0, model_frame()});
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
            if (check_next) begin
                vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL stream_abort_valid: got %b want 0", tx_if.tx_valid); end
                vectors++; if (frames_sent !== 16'd4464) begin miscompares++; $display("FAIL stream_frames_sent: got %0d want 4464", frames_sent); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stream_abort_busy: got %b want 0", busy); end
                vectors++; if (done_seen) begin miscompares++; $display("FAIL stream_abort_done: got done pulse want none"); end
                finished = 1'b1;
            end else begin
                if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
                    obs_w = {tx_if.tx_sof, tx_if.tx_data};
                    exp_w = exp_q.pop_front();
                    vectors++;
                    if (obs_w !== exp_w) begin
                        miscompares++;
                        $display("FAIL stream_beat%0d: got %h want %h", popped, obs_w, exp_w);
                    end
                    if (popped >= SYNC_N) acc++;
                    popped++;
                end
                if (abort_cyc) check_next = 1'b1;
            end
        end
        abort = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL stream_timeout: got %0d accepts want 70000", acc);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        frame_count = '0;
        tx_if.tx_ready = 1'b0;
`ifdef PRBS_SCHED_ERR_INJECT_EN
        err_inj = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_start_abort_idle();
        test_reset_mid();
`ifdef PRBS_SCHED_ERR_INJECT_EN
        test_err_inj();
`endif
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prbs_frame_scheduler.md
# prbs_frame_scheduler

Controller that sequences a 32-bit PRBS7 test-pattern source onto the chip's transmit link. On a start command it reseeds the generator, emits a fixed sync preamble, then streams a programmed number of payload frames (or streams continuously) over a valid/ready handshake, advancing the generator only on accepted beats. It sits between the test/config register block (start, abort, frame count) and the serializer input.

## Interface
- `FRAME_W`, 32: frame width in bits; only 32 is supported.
- `CNT_W`, 16: width of the frame counter and of `frame_count`.
- `SYNC_WORD`, 32'hA5A5_F00F: preamble word.
- `SYNC_LEN`, 2: number of preamble words per run, 1..15.
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: run request pulse; sampled only in IDLE.
- `abort` in 1: terminate the run immediately.
- `frame_count` in CNT_W: payload frames per run, latched on start; 0 means continuous.
- `tx_data` out 32: frame to link.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: link accepts the beat when `tx_valid & tx_ready`.
- `tx_sof` out 1: high with the first sync word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `frames_sent` out CNT_W: accepted payload frames in the current or last run.

## Operation
- Generator: PRBS7, x^7+x^6+1, 7-bit state. New bit = s[6]^s[5], shifted in at s[0]. Each frame is 32 successive bits, first bit at MSB. After a frame the state equals the last 7 bits produced. The generator advances only on accepted payload beats.
- IDLE: `tx_valid`=0. `start`=1 and `abort`=0 latches `frame_count` and moves to SEED.
- SEED, one cycle: generator state = 7'h7F, `frames_sent`=0, sync counter=0. Moves to SYNC.
- SYNC: `tx_valid`=1, `tx_data`=`SYNC_WORD`. `tx_sof`=1 on the first word only. Each accepted beat increments the sync counter. After the `SYNC_LEN`th accept, moves to PAYLOAD.
- PAYLOAD: `tx_valid`=1, `tx_data`=current generator frame. Each accept advances the generator and increments `frames_sent`.
  - Latched count N>0: the Nth accept moves to DONE.
  - N=0: streams until abort; `frames_sent` wraps modulo 2^CNT_W.
- DONE, one cycle: `done`=1, `tx_valid`=0. Moves to IDLE. `frames_sent` holds until the next SEED.
- Valid rule: while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_sof` and `tx_valid` hold stable. The only exception is abort.
- Abort in any non-IDLE state: next state is IDLE and `tx_valid` drops. No `done` pulse. `frames_sent` keeps the count of accepted frames. An accept in the abort cycle still counts.
- Priority: reset > abort > start. `start` while busy is ignored.
- Reset mid-run: all state returns to reset values the next edge; no `done` pulse.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `tx_sof`=0, `busy`=0, `done`=0, `frames_sent`=0, state=IDLE, generator=7'h7F.
- All outputs are registered; no combinational path from `tx_ready` to outputs.
- With `start` in cycle 0: SEED in cycle 1, first `tx_valid` in cycle 2.
- With `tx_ready` held high, `SYNC_LEN`=2 and N frames:
  - sync words in cycles 2–3;
  - payload in cycles 4..3+N;
  - `done` in cycle 4+N;
  - `busy` low from cycle 5+N.
- Throughput: one beat per cycle under continuous ready.
- First payload frame after seed: 32'h020C_28F2. Generator state after that frame: 7'h72.

## Configuration
- `PRBS_SCHED_ERR_INJECT_EN` defined:
  - Adds port `err_inj` (in 1). A pulse arms a one-shot that XORs bit 0 of the next accepted payload frame.
  - The generator sequence is unaffected.
  - The arm flag clears on use, abort or reset.
  - An `err_inj` pulse while already armed has no effect.
- Undefined: the port and the logic are absent; payload is the pure PRBS.

## Structure
- Shared package `prbs_pkg`: state enum (IDLE, SEED, SYNC, PAYLOAD, DONE), `PRBS7_SEED` = 7'h7F, default `SYNC_WORD`, frame width constant.
- Sub-module `prbs7_frame_gen`: 7-bit state, inputs `seed` and `advance`, outputs the 32-bit frame combinationally and the next state.
- Expected size: ~200 lines of RTL.

## Test plan
- Reset, then `frame_count`=3, `start`, `tx_ready`=1:
  - A5A5F00F ×2 with `tx_sof` on the first word;
  - then 020C28F2 and two further frames matching the reference model;
  - `done` in cycle 7; `frames_sent`=3.
- Same run with `tx_ready` toggling 1/0 per cycle: identical data sequence, every stalled beat held stable, `done` later.
- `frame_count`=0: stream 70000 frames, then `abort`. `frames_sent` wraps past 65535 to 4464, `tx_valid` drops next cycle, no `done`.
- `start` during PAYLOAD is ignored. `start` and `abort` in the same IDLE cycle: remains IDLE.
- `reset_n` low mid-PAYLOAD, then a new run: all outputs 0, and the first payload frame is again 020C28F2.
- With `PRBS_SCHED_ERR_INJECT_EN`: pulse `err_inj` in SYNC. The first payload frame is 020C28F3; the second frame matches the model.
